// File: rtl/heart_lives_display_pkg.sv
// Shared graphics definitions for the maze HUD: colour codes, heart sprite geometry
// and the lives FSM state encoding.
package heart_lives_display_pkg;

  localparam logic [2:0] RGB_BLACK = 3'b000;
  localparam logic [2:0] RGB_RED   = 3'b100;

  localparam int unsigned HEART_W   = 25;
  localparam int unsigned HEART_H   = 26;
  localparam int unsigned HEART_COL = 5;

  typedef enum logic [1:0] {
    StAlive = 2'd0,
    StBlink = 2'd1,
    StOver  = 2'd2
  } state_e;

endpackage

// File: rtl/heart_lives_display_if.sv
// Game-event and pixel-path bundle between the game core / pixel mux and the lives HUD.
interface heart_lives_display_if #(
  parameter int unsigned LW = 2
) ();

  logic          frame_tick;
  logic          life_lost;
  logic          restart;
  logic          video_on;
  logic [9:0]    pix_x;
  logic [9:0]    pix_y;
  logic [LW-1:0] lives;
  logic          game_over;
  logic          graph_on;
  logic [2:0]    graph_rgb;

  modport master (
    output frame_tick, life_lost, restart, video_on, pix_x, pix_y,
    input  lives, game_over, graph_on, graph_rgb
  );

  modport slave (
    input  frame_tick, life_lost, restart, video_on, pix_x, pix_y,
    output lives, game_over, graph_on, graph_rgb
  );

endinterface

// File: rtl/heart_lives_display_sprite.sv
// Combinational heart shape test: offsets relative to the slot's top-left corner in,
// hit out. Offsets that wrapped below zero land far outside the box and miss.
module heart_lives_display_sprite
  import heart_lives_display_pkg::*;
(
  input  logic [10:0] dx,
  input  logic [10:0] dy,
  output logic        hit
);

  logic [10:0] col;

  always_comb begin
    hit = 1'b0;
    col = '0;
    if (dx < 11'(HEART_W) && dy < 11'(HEART_H)) begin
      col = dx / 11'(HEART_COL);
      case (col)
        11'd0, 11'd4: hit = (dy >= 11'd5) && (dy <= 11'd15);
        11'd1, 11'd3: hit = (dy <= 11'd20);
        11'd2:        hit = (dy >= 11'd5);
        default:      hit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/heart_lives_display.sv
// Lives HUD: tracks the live count with an ALIVE/BLINK/OVER FSM and draws a row of
// heart sprites, blinking the most recently lost one.
module heart_lives_display
  import heart_lives_display_pkg::*;
#(
  parameter int unsigned MAX_LIVES    = 3,
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned ORIGIN_X     = 430,
  parameter int unsigned ORIGIN_Y     = 420,
  parameter int unsigned PITCH        = 30,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter int unsigned BLINK_HALF   = 4,
  parameter logic [2:0]  HEART_RGB    = RGB_RED
) (
  input logic                  clk,
  input logic                  reset,
  heart_lives_display_if.slave bus
);

  localparam int unsigned LW = $clog2(MAX_LIVES + 1);
  localparam int unsigned BW = $clog2(BLINK_FRAMES) + 1;

  localparam state_e        InitState = (INIT_LIVES == 0) ? StOver : StAlive;
  localparam logic [LW-1:0] InitLives = LW'(INIT_LIVES);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_FRAMES - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [BW-1:0] blink_q, blink_d;

  logic [MAX_LIVES-1:0] hit;
  logic [MAX_LIVES-1:0] slot_en;
  logic                 blink_show;
  int unsigned          blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= InitState;
      lives_q <= InitLives;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    blink_d = blink_q;
    if (bus.restart) begin
      state_d = InitState;
      lives_d = InitLives;
      blink_d = '0;
    end else begin
      case (state_q)
        StAlive: begin
          if (bus.life_lost && lives_q != '0) begin
            lives_d = lives_q - 1'b1;
            blink_d = '0;
            state_d = StBlink;
          end
        end
        StBlink: begin
          if (bus.frame_tick) begin
            // The last blink frame leaves BLINK; the counter parks at its maximum.
            if (blink_q == BlinkLast) begin
              state_d = (lives_q == '0) ? StOver : StAlive;
            end else begin
              blink_d = blink_q + 1'b1;
            end
          end
        end
        StOver:  state_d = StOver;
        default: state_d = InitState;
      endcase
    end
  end

  for (genvar k = 0; k < MAX_LIVES; k++) begin : g_slot
    localparam logic [10:0] SlotX = 11'(ORIGIN_X + k * PITCH);
    logic [10:0] dx;
    logic [10:0] dy;

    assign dx = {1'b0, bus.pix_x} - SlotX;
    assign dy = {1'b0, bus.pix_y} - 11'(ORIGIN_Y);

    heart_lives_display_sprite u_sprite (
      .dx  (dx),
      .dy  (dy),
      .hit (hit[k])
    );
  end

  always_comb begin
    blink_phase   = 32'(blink_q) / BLINK_HALF;
    blink_show    = (blink_phase % 2) == 0;
    bus.lives     = lives_q;
    bus.game_over = (state_q == StOver);
    for (int k = 0; k < MAX_LIVES; k++) begin
      // Slot at index lives is the heart just lost; it only exists while blinking.
      slot_en[k] = (LW'(k) < lives_q) ||
                   ((LW'(k) == lives_q) && (state_q == StBlink) && blink_show);
    end
    bus.graph_on  = bus.video_on && |(hit & slot_en);
    bus.graph_rgb = bus.graph_on ? HEART_RGB : RGB_BLACK;
  end

endmodule

// File: tb/tb_heart_lives_display.sv
// Directed bench for the lives HUD: default 3-slot instance plus a 5-slot, wider-pitch one.
module tb_heart_lives_display;

  logic clk = 1'b0;
  logic reset;

  always #10 clk = ~clk;

  heart_lives_display_if #(.LW(2)) bus0 ();
  heart_lives_display_if #(.LW(3)) bus1 ();

  heart_lives_display u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  heart_lives_display #(
    .MAX_LIVES  (5),
    .INIT_LIVES (5),
    .PITCH      (40)
  ) u_dut_wide (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int unsigned x, input int unsigned y);
    bus0.pix_x = 10'(x);
    bus0.pix_y = 10'(y);
    #1;
  endtask

  task automatic pulse_life();
    bus0.life_lost = 1'b1;
    step();
    bus0.life_lost = 1'b0;
  endtask

  task automatic pulse_tick();
    bus0.frame_tick = 1'b1;
    step();
    bus0.frame_tick = 1'b0;
  endtask

  task automatic run_blink();
    for (int t = 0; t < 16; t++) pulse_tick();
  endtask

  initial begin
    reset           = 1'b1;
    bus0.frame_tick = 1'b0;
    bus0.life_lost  = 1'b0;
    bus0.restart    = 1'b0;
    bus0.video_on   = 1'b1;
    bus0.pix_x      = '0;
    bus0.pix_y      = '0;
    bus1.frame_tick = 1'b0;
    bus1.life_lost  = 1'b0;
    bus1.restart    = 1'b0;
    bus1.video_on   = 1'b1;
    bus1.pix_x      = 10'd595;
    bus1.pix_y      = 10'd430;
    step();
    step();
    reset = 1'b0;
    step();

    check("reset_lives", bus0.lives, 3);
    check("reset_game_over", bus0.game_over, 0);
    probe(430, 425);
    check("slot0_on", bus0.graph_on, 1);
    check("slot0_rgb", bus0.graph_rgb, 3'b100);
    probe(432, 421);
    check("slot0_top_gap", bus0.graph_on, 0);
    probe(472, 420);
    check("slot1_centre_top_gap", bus0.graph_on, 0);
    probe(472, 445);
    check("slot1_centre_bottom", bus0.graph_on, 1);
    probe(500, 430);
    check("slot2_full_lives", bus0.graph_on, 1);
    probe(429, 425);
    check("left_of_slot0", bus0.graph_on, 0);

    // First hit: slot 2 blinks 4 frames on / 4 off; a mid-blink hit is ignored.
    pulse_life();
    check("hit1_lives", bus0.lives, 2);
    for (int t = 0; t < 16; t++) begin
      if (t == 5) begin
        pulse_life();
        check("invulnerable_lives", bus0.lives, 2);
      end
      probe(500, 430);
      check($sformatf("blink_t%0d", t), bus0.graph_on, ((t / 4) % 2) == 0);
      pulse_tick();
    end
    probe(500, 430);
    check("blink_done_off", bus0.graph_on, 0);
    check("blink_done_lives", bus0.lives, 2);
    check("blink_done_game_over", bus0.game_over, 0);
    probe(470, 430);
    check("slot1_still_solid", bus0.graph_on, 1);

    pulse_life();
    check("hit2_lives", bus0.lives, 1);
    run_blink();
    pulse_life();
    check("hit3_lives", bus0.lives, 0);
    check("hit3_blink_not_over", bus0.game_over, 0);
    probe(440, 430);
    check("slot0_blink_visible", bus0.graph_on, 1);
    run_blink();
    check("over_game_over", bus0.game_over, 1);
    probe(440, 430);
    check("over_slot0_off", bus0.graph_on, 0);
    probe(430, 425);
    check("over_no_heart", bus0.graph_on, 0);
    pulse_life();
    check("over_hit_lives", bus0.lives, 0);
    check("over_hit_game_over", bus0.game_over, 1);

    // Restart wins over a simultaneous hit.
    bus0.restart   = 1'b1;
    bus0.life_lost = 1'b1;
    step();
    bus0.restart   = 1'b0;
    bus0.life_lost = 1'b0;
    check("restart_lives", bus0.lives, 3);
    check("restart_game_over", bus0.game_over, 0);
    probe(430, 425);
    check("restart_slot0_on", bus0.graph_on, 1);
    pulse_life();
    check("restart_alive_accepts_hit", bus0.lives, 2);

    bus0.video_on = 1'b0;
    probe(430, 425);
    check("blank_graph_on", bus0.graph_on, 0);
    check("blank_rgb", bus0.graph_rgb, 3'b000);
    bus0.video_on = 1'b1;

    check("wide_lives", bus1.lives, 5);
    check("wide_slot4_hit", bus1.graph_on, 1);
    bus1.pix_x = 10'd589;
    #1;
    check("wide_gap_before_slot4", bus1.graph_on, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
